// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multi-cycle RV32M multiply/divide/remainder sequencer
module muldiv_sequencer #(
    parameter int N     = 32,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         flush,
    output logic         stall,
    output logic         done,
    output logic [N-1:0] result,
    output logic         busy
);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [N-1:0] MIN_NEG  = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] ALL_ONES = {N{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_next;

    logic [2:0]     op_r;
    logic           neg_a, neg_b;
    logic [N-1:0]   mag_a, mag_b;
    logic [CNT_W-1:0] cnt;
    logic [2*N-1:0] acc;

    logic           accept;
    logic           fix_write;
    logic           signed_a_in, signed_b_in;
    logic           neg_a_in, neg_b_in;
    logic [N-1:0]   mag_a_in, mag_b_in;
    logic           fast_div0, fast_ovf, fast;
    logic [N-1:0]   fast_val;

    logic [N:0]     mul_sum;
    logic [2*N-1:0] mul_next;
    logic [N:0]     rem_sh;
    logic [N:0]     diff;
    logic [2*N-1:0] div_next;

    logic [2*N-1:0] prod;
    logic [N-1:0]   quot, remv;
    logic [N-1:0]   fix_val;

    // Operand decode for the accept cycle
    assign signed_a_in = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                         (op == OP_DIV) || (op == OP_REM);
    assign signed_b_in = (op == OP_MUL) || (op == OP_MULH) ||
                         (op == OP_DIV) || (op == OP_REM);
    assign neg_a_in    = signed_a_in & a[N-1];
    assign neg_b_in    = signed_b_in & b[N-1];
    assign mag_a_in    = neg_a_in ? (~a + 1'b1) : a;
    assign mag_b_in    = neg_b_in ? (~b + 1'b1) : b;

    assign fast_div0 = op[2] && (b == '0);
    assign fast_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_NEG) && (b == ALL_ONES);
    assign fast      = fast_div0 || fast_ovf;

    always_comb begin
        fast_val = '0;
        if (fast_div0) begin
            fast_val = op[1] ? a : ALL_ONES;
        end else begin
            fast_val = op[1] ? '0 : MIN_NEG;
        end
    end

    assign accept = (state == IDLE) && start && !flush;

    // Shift-add: add |a| into the high half when the multiplier LSB is set, then shift right
    assign mul_sum  = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, mag_a} : {(N+1){1'b0}});
    assign mul_next = {mul_sum, acc[N-1:1]};

    // Restoring division: borrow out of the (N+1)-bit subtraction means rem < |b|
    assign rem_sh   = {acc[2*N-1:N], acc[N-1]};
    assign diff     = rem_sh - {1'b0, mag_b};
    assign div_next = diff[N] ? {rem_sh[N-1:0], acc[N-2:0], 1'b0}
                              : {diff[N-1:0],   acc[N-2:0], 1'b1};

    assign prod = (neg_a ^ neg_b) ? (~acc + 1'b1) : acc;
    assign quot = (neg_a ^ neg_b) ? (~acc[N-1:0] + 1'b1) : acc[N-1:0];
    assign remv = neg_a ? (~acc[2*N-1:N] + 1'b1) : acc[2*N-1:N];

    always_comb begin
        fix_val = '0;
        case (op_r)
            OP_MUL:                        fix_val = prod[N-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_val = prod[2*N-1:N];
            OP_DIV, OP_DIVU:               fix_val = quot;
            OP_REM, OP_REMU:               fix_val = remv;
            default:                       fix_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        fix_write  = 1'b0;
        stall      = 1'b0;
        done       = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                stall = start && !flush;
                if (accept) begin
                    state_next = fast ? DONE : CALC;
                end
            end
            CALC: begin
                stall = 1'b1;
                if (flush) begin
                    state_next = IDLE;
                end else if (cnt == CNT_W'(1)) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                stall = 1'b1;
                if (flush) begin
                    state_next = IDLE;
                end else begin
                    fix_write  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_r   <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            mag_a  <= '0;
            mag_b  <= '0;
            cnt    <= '0;
            acc    <= '0;
            result <= '0;
        end else if (accept) begin
            op_r  <= op;
            neg_a <= neg_a_in;
            neg_b <= neg_b_in;
            mag_a <= mag_a_in;
            mag_b <= mag_b_in;
            cnt   <= CNT_W'(N);
            // Dividend seeds the quotient half; for multiply the multiplier |b| does
            acc   <= op[2] ? {{N{1'b0}}, mag_a_in} : {{N{1'b0}}, mag_b_in};
            if (fast) begin
                result <= fast_val;
            end
        end else if (state == CALC) begin
            cnt <= cnt - 1'b1;
            acc <= op_r[2] ? div_next : mul_next;
        end else if (fix_write) begin
            result <= fix_val;
        end
    end

endmodule
